// File: rtl/tour_cmd_seq.sv
// Knight's-tour replay sequencer: fetches each one-hot move and issues a vertical then a horizontal leg to cmd_proc.
// Optional feature: define TOUR_ABORT_EN to let a UART command end the tour after the current move.
module tour_cmd_seq #(
  parameter int         BOARD_DIM = 5,
  parameter int         IDX_W     = 5,
  parameter logic [3:0] OPC_VERT  = 4'h2,
  parameter logic [3:0] OPC_HORZ  = 4'h3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_err
);

  localparam int               NUM_MOVES = BOARD_DIM * BOARD_DIM - 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MOVES - 1);
  localparam logic [7:0]       HEAD_N    = 8'h00;
  localparam logic [7:0]       HEAD_W    = 8'h3F;
  localparam logic [7:0]       HEAD_S    = 8'h7F;
  localparam logic [7:0]       HEAD_E    = 8'hBF;

  typedef enum logic [2:0] {IDLE, FETCH, VERT, VWAIT, HORZ, HWAIT} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] indx_reg, indx_next;
  logic [7:0]       move_q_reg, move_q_next;
  logic             err_reg, err_next;
  logic             abort_pend;
  logic             usurp, last_move, move_valid;
  logic [7:0]       vhead, hhead;
  logic [3:0]       vsq, hsq;
  logic [15:0]      tour_cmd;

  assign usurp      = (state_reg != IDLE);
  assign last_move  = (indx_reg == LAST_IDX);
  assign move_valid = (move != 8'd0) && ((move & (move - 8'd1)) == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      indx_reg   <= '0;
      move_q_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      indx_reg   <= indx_next;
      move_q_reg <= move_q_next;
      err_reg    <= err_next;
    end
  end

`ifdef TOUR_ABORT_EN
  logic abort_reg, abort_next;

  // A UART request during the tour is remembered and honoured at the next move boundary.
  always_comb begin
    abort_next = abort_reg;
    if (usurp && cmd_rdy_UART) abort_next = 1'b1;
    if (state_next == IDLE)    abort_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) abort_reg <= 1'b0;
    else        abort_reg <= abort_next;
  end

  assign abort_pend = abort_reg;
`else
  assign abort_pend = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    indx_next   = indx_reg;
    move_q_next = move_q_reg;
    err_next    = err_reg;
    case (state_reg)
      IDLE: if (start_tour) begin
        indx_next  = '0;
        err_next   = 1'b0;
        state_next = FETCH;
      end
      FETCH: begin
        move_q_next = move;
        if (!move_valid) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = VERT;
        end
      end
      VERT:  if (clr_cmd_rdy) state_next = VWAIT;
      VWAIT: if (send_resp)   state_next = HORZ;
      HORZ:  if (clr_cmd_rdy) state_next = HWAIT;
      HWAIT: if (send_resp) begin
        if (last_move || abort_pend) begin
          state_next = IDLE;
        end else begin
          indx_next  = indx_reg + 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Leg decode: bit index selects one of the eight knight moves.
  always_comb begin
    vhead = HEAD_N; vsq = 4'd0; hhead = HEAD_W; hsq = 4'd0;
    case (move_q_reg)
      8'h01: begin vhead = HEAD_N; vsq = 4'd2; hhead = HEAD_W; hsq = 4'd1; end
      8'h02: begin vhead = HEAD_N; vsq = 4'd2; hhead = HEAD_E; hsq = 4'd1; end
      8'h04: begin vhead = HEAD_N; vsq = 4'd1; hhead = HEAD_W; hsq = 4'd2; end
      8'h08: begin vhead = HEAD_S; vsq = 4'd1; hhead = HEAD_W; hsq = 4'd2; end
      8'h10: begin vhead = HEAD_S; vsq = 4'd2; hhead = HEAD_W; hsq = 4'd1; end
      8'h20: begin vhead = HEAD_S; vsq = 4'd2; hhead = HEAD_E; hsq = 4'd1; end
      8'h40: begin vhead = HEAD_S; vsq = 4'd1; hhead = HEAD_E; hsq = 4'd2; end
      8'h80: begin vhead = HEAD_N; vsq = 4'd1; hhead = HEAD_E; hsq = 4'd2; end
      default: ;
    endcase
  end

  assign tour_cmd = (state_reg == HORZ || state_reg == HWAIT) ? {OPC_HORZ, hhead, hsq}
                                                              : {OPC_VERT, vhead, vsq};

  assign cmd       = usurp ? tour_cmd : cmd_UART;
  assign cmd_rdy   = usurp ? (state_reg == VERT || state_reg == HORZ) : cmd_rdy_UART;
  assign resp      = (state_reg == HWAIT && (last_move || abort_pend)) ? 8'hA5 : 8'h5A;
  assign mv_indx   = indx_reg;
  assign tour_busy = usurp;
  assign tour_err  = err_reg;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq: a cmd_proc model serves each leg and compares it against a queue of expected commands.
// Honours TOUR_ABORT_EN for the busy-lockout scenario.
module tb_tour_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0;
  logic        cmd_rdy_UART = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;
  logic        tour_busy;
  logic        tour_err;

  logic [7:0]  move_tab [0:31];
  logic [15:0] exp_q [$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          last_wait = 0;

  always #5 clk = ~clk;

  assign move = move_tab[mv_indx];

  tour_cmd_seq dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
    .tour_busy(tour_busy), .tour_err(tour_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Reference leg table: vertical {4'h2, head, sq} then horizontal {4'h3, head, sq}.
  function automatic logic [15:0] leg_cmd(input logic [7:0] m, input bit horz);
    logic [11:0] v, h;
    case (m)
      8'h01: begin v = 12'h002; h = 12'h3F1; end
      8'h02: begin v = 12'h002; h = 12'hBF1; end
      8'h04: begin v = 12'h001; h = 12'h3F2; end
      8'h08: begin v = 12'h7F1; h = 12'h3F2; end
      8'h10: begin v = 12'h7F2; h = 12'h3F1; end
      8'h20: begin v = 12'h7F2; h = 12'hBF1; end
      8'h40: begin v = 12'h7F1; h = 12'hBF2; end
      default: begin v = 12'h001; h = 12'hBF2; end
    endcase
    return horz ? {4'h3, h} : {4'h2, v};
  endfunction

  task automatic pulse_start();
    @(negedge clk); start_tour = 1'b1;
    @(negedge clk); start_tour = 1'b0;
  endtask

  // Wait for cmd_rdy, compare against the scoreboard, accept, then complete with send_resp.
  task automatic serve_leg(input logic [7:0] exp_resp, input bit poke, input string tag);
    int waited = 0;
    logic [15:0] want;
    while (!cmd_rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    last_wait = waited;
    if (!cmd_rdy) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      return;
    end
    want = exp_q.pop_front();
    check({tag, " cmd"}, cmd, want);
    $display("[TB] idx %0d %s cmd %h", mv_indx, tag, cmd);
    clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
    check({tag, " rdy_low"}, cmd_rdy, 1'b0);
    check({tag, " resp"}, resp, exp_resp);
    if (poke) begin
      start_tour = 1'b1; cmd_rdy_UART = 1'b1; cmd_UART = 16'h2001;
      @(negedge clk); start_tour = 1'b0;
      check("lockout cmd", cmd, want);
      check("lockout rdy", cmd_rdy, 1'b0);
      check("lockout busy", tour_busy, 1'b1);
    end
    send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0;
  endtask

  task automatic run_tour(input int n_moves, input int a5_idx, input int poke_idx);
    pulse_start();
    for (int i = 0; i < n_moves; i++) begin
      exp_q.push_back(leg_cmd(move_tab[i], 1'b0));
      exp_q.push_back(leg_cmd(move_tab[i], 1'b1));
      serve_leg(8'h5A, i == poke_idx, "vert");
      if (i == 0) check("latency", last_wait, 1);
      serve_leg((i == a5_idx) ? 8'hA5 : 8'h5A, 1'b0, "horz");
      check("mv_indx", mv_indx, (i == a5_idx) ? i : i + 1);
    end
    check("end busy", tour_busy, 1'b0);
    check("end resp", resp, 8'h5A);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) move_tab[i] = 8'h40;

    repeat (2) @(negedge clk);
    check("rst mv_indx", mv_indx, 0);
    check("rst busy", tour_busy, 1'b0);
    check("rst err", tour_err, 1'b0);
    check("rst resp", resp, 8'h5A);
    check("rst cmd_rdy", cmd_rdy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    cmd_UART = 16'h2001; cmd_rdy_UART = 1'b1; #1;
    check("idle cmd", cmd, 16'h2001);
    check("idle rdy", cmd_rdy, 1'b1);
    check("idle busy", tour_busy, 1'b0);
    check("idle resp", resp, 8'h5A);
    cmd_rdy_UART = 1'b0;

    move_tab[0] = 8'h01;
    for (int i = 1; i < 24; i++) move_tab[i] = 8'h01 << $urandom_range(0, 7);
    run_tour(24, 23, -1);

    for (int i = 0; i < 24; i++) move_tab[i] = 8'h40;
    run_tour(24, 23, -1);

    move_tab[0] = 8'h03;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      check("bad rdy", cmd_rdy, 1'b0);
      @(negedge clk);
    end
    check("bad err", tour_err, 1'b1);
    check("bad busy", tour_busy, 1'b0);
    check("bad mv_indx", mv_indx, 0);

    move_tab[0] = 8'h80;
    pulse_start();
    check("err cleared", tour_err, 1'b0);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(leg_cmd(move_tab[i], 1'b0));
      exp_q.push_back(leg_cmd(move_tab[i], 1'b1));
      serve_leg(8'h5A, 1'b0, "vert");
      serve_leg(8'h5A, 1'b0, "horz");
    end
    exp_q.push_back(leg_cmd(move_tab[7], 1'b0));
    serve_leg(8'h5A, 1'b0, "vert");
    for (int w = 0; w < 10 && !cmd_rdy; w++) @(negedge clk);
    check("pre-rst rdy", cmd_rdy, 1'b1);
    check("pre-rst mv_indx", mv_indx, 7);
    check("pre-rst cmd", cmd, leg_cmd(move_tab[7], 1'b1));
    rst_n = 1'b0; #1;
    check("midrst mv_indx", mv_indx, 0);
    check("midrst busy", tour_busy, 1'b0);
    check("midrst rdy", cmd_rdy, 1'b0);
    cmd_rdy_UART = 1'b1; #1;
    check("midrst rdy_uart", cmd_rdy, 1'b1);
    cmd_rdy_UART = 1'b0;
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    move_tab[0] = 8'h40;
`ifdef TOUR_ABORT_EN
    run_tour(1, 0, 0);
`else
    run_tour(24, 23, 0);
`endif
    @(negedge clk);
    check("held cmd", cmd, 16'h2001);
    check("held rdy", cmd_rdy, 1'b1);
    check("held busy", tour_busy, 1'b0);
    cmd_rdy_UART = 1'b0;
    check("queue empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Parametrised tour-replay sequencer between TourLogic, UART_wrapper and cmd_proc.
- After a solved tour it fetches each one-hot move by index and breaks it into a vertical leg command and a horizontal leg command.
- It holds the cmd_proc interface ("usurp") for the whole tour and passes UART commands through otherwise.
- Over the fixed 5x5 predecessor it adds: board size, opcode and index-width parameters; registered move fetch; invalid-move detection; busy/error status; optional abort.

Parameters:
- BOARD_DIM, 5, board edge length; NUM_MOVES = BOARD_DIM*BOARD_DIM-1 (24 at default).
- IDX_W, 5, width of mv_indx; must satisfy 2**IDX_W >= NUM_MOVES.
- OPC_VERT, 4'h2, opcode of the vertical leg.
- OPC_HORZ, 4'h3, opcode of the horizontal leg (move with fanfare).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start_tour  in  1  pulse from TourLogic when the tour is solved
- move  in  8  one-hot move read at mv_indx, valid 1 clk after mv_indx changes
- mv_indx  out  IDX_W  move index, registered
- cmd_UART  in  16  command from UART_wrapper
- cmd_rdy_UART  in  1  command ready from UART_wrapper
- cmd  out  16  muxed command to cmd_proc
- cmd_rdy  out  1  muxed command ready to cmd_proc
- clr_cmd_rdy  in  1  cmd_proc accepted the command
- send_resp  in  1  cmd_proc finished the command
- resp  out  8  8'hA5 = tour done, 8'h5A = in progress/ack
- tour_busy  out  1  high while usurping
- tour_err  out  1  sticky: invalid move seen

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values: mv_indx=0, move_q=0, state=IDLE, tour_busy=0, tour_err=0. With usurp low, cmd=cmd_UART, cmd_rdy=cmd_rdy_UART and resp=8'h5A.
- Command format: {opcode[3:0], heading[7:0], squares[3:0]}.
- Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- move_q bit to (vertical leg, horizontal leg):
  - b0: N2, W1
  - b1: N2, E1
  - b2: N1, W2
  - b3: S1, W2
  - b4: S2, W1
  - b5: S2, E1
  - b6: S1, E2
  - b7: N1, E2
- Vertical command = {OPC_VERT, vhead, vsq}. Horizontal command = {OPC_HORZ, hhead, hsq}.
- States:
  - IDLE: start_tour -> mv_indx<=0, clear tour_err, go to FETCH.
  - FETCH: 1 clk. Capture move into move_q. If move is not exactly one-hot: set tour_err, go to IDLE, issue no command. Otherwise go to VERT.
  - VERT: cmd_rdy=1 with the vertical command. clr_cmd_rdy -> VWAIT.
  - VWAIT: cmd_rdy=0. send_resp -> HORZ.
  - HORZ: cmd_rdy=1 with the horizontal command. clr_cmd_rdy -> HWAIT.
  - HWAIT: cmd_rdy=0. On send_resp: if mv_indx==NUM_MOVES-1 go to IDLE; else mv_indx<=mv_indx+1 and go to FETCH.
- Usurp timing: usurp (= tour_busy) is high in every state except IDLE. It is registered, so it changes on the clock edge of the state change.
- resp = 8'hA5 only when state==HWAIT and mv_indx==NUM_MOVES-1; 8'h5A otherwise.
- Command latency: first command appears 2 clks after start_tour (IDLE->FETCH->VERT).
- Per-move cost: each move costs 1 FETCH clk plus the cmd_proc handshakes.
- Ignored inputs:
  - clr_cmd_rdy outside VERT/HORZ.
  - send_resp outside VWAIT/HWAIT.
  - start_tour while busy.
- clr_cmd_rdy and send_resp asserted in the same clk in VERT: only clr_cmd_rdy is taken; the state goes to VWAIT.
- While busy, cmd_rdy_UART is not forwarded. UART_wrapper keeps holding it, and it is delivered once the state returns to IDLE.
- mv_indx never exceeds NUM_MOVES-1. It holds its final value after the tour.
- rst_n asserted mid-tour: immediate return to reset values. A partially issued command is dropped.

Optional Feature:
- Macro: TOUR_ABORT_EN.
- Defined:
  - cmd_rdy_UART asserted while busy sets abort_pend.
  - In HWAIT, send_resp with abort_pend set goes to IDLE and clears abort_pend.
  - resp = 8'hA5 for that final response, so the host sees completion.
  - The held UART command then passes through.
  - A move in progress always completes; aborts never split vertical and horizontal legs.
- Undefined: no abort_pend logic; cmd_rdy_UART is ignored until the tour ends.

Test Plan:
- Idle pass-through: cmd_UART=16'h2001 with cmd_rdy_UART=1 -> cmd=16'h2001, cmd_rdy=1, tour_busy=0, resp=8'h5A.
- Single move: start_tour, move=8'h01 -> cmd=16'h2002, then after clr_cmd_rdy/send_resp cmd=16'h33F1; mv_indx 0->1 after the second send_resp.
- Full tour: move=8'h40 at every index, BOARD_DIM=5 -> 48 commands alternating 16'h27F1 / 16'h3BF2; resp=8'hA5 only in the last HWAIT; IDLE after the 24th move with mv_indx=23.
- Invalid move: move=8'h03 at index 0 -> no cmd_rdy, tour_err=1, back to IDLE. A following start_tour clears tour_err.
- Busy lockout: start_tour and cmd_rdy_UART=1 pulsed in VWAIT -> no restart; cmd unchanged; the UART command is delivered after the tour (macro off). With TOUR_ABORT_EN: IDLE after the current move's HWAIT send_resp, resp=8'hA5.
- Reset mid-tour: rst_n low in HORZ at mv_indx=7 -> mv_indx=0, cmd_rdy follows cmd_rdy_UART, tour_busy=0 in the same cycle.
